instr_fetch: RTL and testbench

Instruction fetch stage of the pipelined RV32 CPU. It maintains the fetch PC, issues word requests to instruction memory, and buffers returned words with their PCs in a small queue. It presents `{instr, pc, halt}` to the decode stage and honours stall and redirect from the downstream pipeline. While no valid instruction is buffered, it injects a NOP so decode always sees a legal opcode.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 71 +++++++
 rtl/instr_fetch.sv | 114 +++++++++++
 tb/tb_instr_fetch.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared constants and types for the instruction fetch stage
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - small synchronous FIFO holding fetched {instr, pc} entries
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  // Flush wins over both push and pop.
  always_comb begin
    do_push  = push & ~full & ~flush;
    do_pop   = pop & ~empty & ~flush;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) mem_d[wr_ptr_q] = push_data;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
      else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head_data = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign full      = (count_q == CNT_MAX);
  assign empty     = (count_q == '0);

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch PC, single-outstanding imem requests and decode-facing queue
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall_in_if,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_in_if,
  output logic        valid_out_if,
  output logic [31:0] instr_out_if,
  output logic [31:0] pc_out_if,
  output logic        halt_out_if
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e state_q, state_d;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q, req_pc_d;
  logic         halt_q, halt_d;

  logic         req_fire, redirect_take, misaligned;
  logic         push, pop, flush;
  logic [CW-1:0] fifo_count;
  logic         fifo_full, fifo_empty;
  fetch_entry_t push_entry, head;

  assign req_fire      = imem_req_valid & imem_req_ready;
  assign redirect_take = redirect_valid & (state_q != HALTED);
  assign misaligned    = (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      halt_q     <= halt_d;
    end
  end

  // A redirect turns any request still owed to us (including one accepted this cycle) into a drop.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:       if (req_fire) state_d = WAIT;
      WAIT, DROP: if (imem_rsp_valid) state_d = IDLE;
      HALTED:     state_d = HALTED;
    endcase
    if (redirect_take) begin
      if (misaligned)              state_d = HALTED;
      else if (state_d == WAIT)    state_d = DROP;
    end
    if (halt_in_if) state_d = HALTED;
  end

  always_comb begin
    imem_req_valid = (state_q == IDLE) && (fifo_count < CW'(DEPTH)) && !rst;
  end

  assign imem_req_addr = fetch_pc_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (req_fire) fetch_pc_d = fetch_pc_q + 32'd4;
    if (redirect_take && !misaligned) fetch_pc_d = redirect_pc;
    req_pc_d = req_fire ? fetch_pc_q : req_pc_q;
    halt_d   = halt_q | halt_in_if | (redirect_take & misaligned);
  end

  always_comb begin
    push_entry.instr = imem_rsp_data;
    push_entry.pc    = req_pc_q;
    push  = (state_q == WAIT) & imem_rsp_valid & ~redirect_take & ~halt_in_if & ~fifo_full;
    pop   = valid_out_if & ~stall_in_if;
    flush = redirect_take;
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign valid_out_if = ~fifo_empty;
  assign instr_out_if = fifo_empty ? NOP_INSTR : head.instr;
  assign pc_out_if    = fifo_empty ? fetch_pc_q : head.pc;
  assign halt_out_if  = halt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed and random checks of instr_fetch against a queue-level model
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  localparam int          DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall_in_if;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_in_if;
  logic        valid_out_if;
  logic [31:0] instr_out_if;
  logic [31:0] pc_out_if;
  logic        halt_out_if;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .stall_in_if    (stall_in_if),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_in_if     (halt_in_if),
    .valid_out_if   (valid_out_if),
    .instr_out_if   (instr_out_if),
    .pc_out_if      (pc_out_if),
    .halt_out_if    (halt_out_if)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Stimulus knobs for the next cycle.
  bit          k_rdy = 1'b1, k_stall = 1'b0, k_redir = 1'b0, k_halt = 1'b0, k_rst = 1'b1;
  logic [31:0] k_rpc = 32'h0;
  int          mem_lat = 1;

  // Instruction memory: one request in flight, fixed latency captured at accept.
  bit          mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt  = 0;

  // Reference model: fetch PC, the one owed response and whether it is wanted, and the queue.
  bit          m_out = 1'b0, m_keep = 1'b0, m_halted = 1'b0, m_halt = 1'b0;
  logic [31:0] m_pc = RPC, m_req_pc = RPC;
  logic [63:0] m_q[$];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
  endfunction

  function automatic bit exp_req();
    return !k_rst && !m_halted && !m_out && (m_q.size() < DEPTH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    logic [63:0] head;
    chk("imem_req_valid", 32'(imem_req_valid), 32'(exp_req()));
    if (exp_req()) chk("imem_req_addr", imem_req_addr, m_pc);
    chk("valid_out_if", 32'(valid_out_if), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      chk("instr_out_if", instr_out_if, head[63:32]);
      chk("pc_out_if", pc_out_if, head[31:0]);
    end else begin
      chk("instr_out_if nop", instr_out_if, NOP_INSTR);
    end
    chk("halt_out_if", 32'(halt_out_if), 32'(m_halt));
  endtask

  task automatic step();
    bit          rsp_now, fire, pop, redir_take, acc, kept;
    logic [31:0] pre_pc;
    rst            = k_rst;
    imem_req_ready = k_rdy;
    stall_in_if    = k_stall;
    redirect_valid = k_redir;
    redirect_pc    = k_rpc;
    halt_in_if     = k_halt;
    rsp_now = 1'b0;
    if (mem_busy) begin
      mem_cnt--;
      if (mem_cnt <= 0) rsp_now = 1'b1;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? word_at(mem_addr) : $urandom();
    fire   = exp_req() && k_rdy;
    pre_pc = m_pc;
    @(posedge clk);
    if (rsp_now) mem_busy = 1'b0;
    if (fire) begin
      mem_busy = 1'b1;
      mem_addr = pre_pc;
      mem_cnt  = mem_lat;
    end
    if (k_rst) begin
      m_out = 0; m_keep = 0; m_halted = 0; m_halt = 0; m_pc = RPC;
      m_q.delete();
    end else begin
      pop        = (m_q.size() != 0) && !k_stall;
      redir_take = k_redir && !m_halted;
      acc        = m_out && rsp_now;
      kept       = acc && m_keep && !redir_take && !k_halt && !m_halted;
      if (redir_take) m_q.delete();
      else begin
        if (pop)  void'(m_q.pop_front());
        if (kept) m_q.push_back({word_at(m_req_pc), m_req_pc});
      end
      if (acc) m_out = 1'b0;
      if (fire) begin
        m_out = 1'b1; m_keep = 1'b1; m_req_pc = m_pc; m_pc = m_pc + 32'd4;
      end
      if (redir_take) begin
        m_keep = 1'b0;
        if (k_rpc[1:0] != 2'b00) begin m_halted = 1'b1; m_halt = 1'b1; end
        else m_pc = k_rpc;
      end
      if (k_halt) begin m_halted = 1'b1; m_halt = 1'b1; m_keep = 1'b0; end
    end
    k_redir = 1'b0;
    k_halt  = 1'b0;
    #1;
    check_all();
  endtask

  task automatic do_reset();
    k_rst = 1'b1; k_rdy = 1'b1; k_stall = 1'b0; mem_lat = 1;
    step();
    step();
    chk("reset imem_req_valid", 32'(imem_req_valid), 32'h0);
    chk("reset valid_out_if", 32'(valid_out_if), 32'h0);
    chk("reset instr_out_if", instr_out_if, NOP_INSTR);
    chk("reset pc_out_if", pc_out_if, RPC);
    chk("reset halt_out_if", 32'(halt_out_if), 32'h0);
    k_rst = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
    int n = 0;
    do begin
      step();
      n++;
    end while (valid_out_if !== 1'b1 && n < 30);
    chk({tag, " valid"}, 32'(valid_out_if), 32'h1);
    chk({tag, " pc"}, pc_out_if, exp_pc);
    chk({tag, " instr"}, instr_out_if, word_at(exp_pc));
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    stall_in_if = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_in_if = 1'b0;

    // In-order fetch with 1-cycle memory.
    do_reset();
    wait_valid("seq 0x0", 32'h0);
    wait_valid("seq 0x4", 32'h4);
    wait_valid("seq 0x8", 32'h8);

    // Stall fills the queue and blocks issue.
    do_reset();
    k_stall = 1'b1;
    repeat (6) step();
    chk("stall req_valid", 32'(imem_req_valid), 32'h0);
    chk("stall hold pc", pc_out_if, 32'h0);
    k_stall = 1'b0;
    step();
    chk("release pc", pc_out_if, 32'h4);
    step();
    wait_valid("after stall", 32'h8);

    // Redirect with the 0x8 request still in flight.
    do_reset();
    repeat (4) step();
    mem_lat = 3;
    step();
    mem_lat = 1;
    k_redir = 1'b1; k_rpc = 32'h100;
    step();
    wait_valid("redir inflight", 32'h100);

    // Redirect in the same cycle as the 0x8 response.
    do_reset();
    repeat (5) step();
    k_redir = 1'b1; k_rpc = 32'h100;
    step();
    wait_valid("redir with rsp", 32'h100);

    // Misaligned redirect halts.
    do_reset();
    step();
    k_redir = 1'b1; k_rpc = 32'h102;
    step();
    chk("misalign halt", 32'(halt_out_if), 32'h1);
    repeat (5) begin
      step();
      chk("misalign no req", 32'(imem_req_valid), 32'h0);
    end

    // Halt with two queued entries: they still drain.
    do_reset();
    k_stall = 1'b1;
    repeat (6) step();
    k_halt = 1'b1;
    step();
    chk("halt_in halt", 32'(halt_out_if), 32'h1);
    chk("halt_in head pc", pc_out_if, 32'h0);
    k_stall = 1'b0;
    step();
    chk("halt drain pc", pc_out_if, 32'h4);
    step();
    chk("halt drained", 32'(valid_out_if), 32'h0);
    chk("halt sticky", 32'(halt_out_if), 32'h1);
    chk("halt no req", 32'(imem_req_valid), 32'h0);

    // Fetch PC wraps past the top of the address space.
    do_reset();
    k_redir = 1'b1; k_rpc = 32'hFFFF_FFFC;
    step();
    wait_valid("wrap hi", 32'hFFFF_FFFC);
    wait_valid("wrap lo", 32'h0);

    // Reset while a request is outstanding; the late response is ignored.
    do_reset();
    mem_lat = 3;
    step();
    mem_lat = 1;
    k_rst = 1'b1;
    step();
    step();
    k_rst = 1'b0;
    wait_valid("post reset", 32'h0);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      k_rdy   = ($urandom_range(0, 3) != 0);
      k_stall = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) begin
        k_redir = 1'b1;
        k_rpc   = $urandom() & 32'hFFFF_FFFC;
        if ($urandom_range(0, 7) == 0) k_rpc[0] = 1'b1;
      end
      k_halt  = ($urandom_range(0, 63) == 0);
      k_rst   = ($urandom_range(0, 31) == 0);
      mem_lat = $urandom_range(1, 3);
      step();
    end
    k_rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
